// File: rtl/icap_pkg.sv
// Shared ICAP command words and sequencer state encoding for the multiboot block.
package icap_pkg;

  localparam logic [15:0] ICAP_DUMMY = 16'hFFFF;
  localparam logic [15:0] ICAP_SYNC0 = 16'hAA99;
  localparam logic [15:0] ICAP_SYNC1 = 16'h5566;
  localparam logic [15:0] ICAP_GEN1  = 16'h3261;
  localparam logic [15:0] ICAP_GEN2  = 16'h3281;
  localparam logic [15:0] ICAP_GEN3  = 16'h32A1;
  localparam logic [15:0] ICAP_GEN4  = 16'h32C1;
  localparam logic [15:0] ICAP_CMD   = 16'h30A1;
  localparam logic [15:0] ICAP_IPROG = 16'h000E;
  localparam logic [15:0] ICAP_NOOP  = 16'h2000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SEND  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } icap_state_t;

endpackage

// File: rtl/icap_iprog_rom.sv
// Combinational word map for the IPROG stream: word index -> 16-bit ICAP word.
// Indices below DUMMY_WORDS are dummy pads; anything past the IPROG command is a NOOP.
module icap_iprog_rom
  import icap_pkg::*;
#(
  parameter int DUMMY_WORDS = 4,
  parameter int IDX_W       = 5
) (
  input  logic [IDX_W-1:0] i_idx,
  input  logic [23:0]      i_addr,
  input  logic [7:0]       i_opcode,
  input  logic [23:0]      i_fallback,
  output logic [15:0]      o_word
);

  logic [IDX_W-1:0] w_rel;

  assign w_rel = i_idx - IDX_W'(DUMMY_WORDS);

  always_comb begin
    o_word = ICAP_NOOP;
    if (i_idx < IDX_W'(DUMMY_WORDS)) begin
      o_word = ICAP_DUMMY;
    end else begin
      case (w_rel)
        IDX_W'(0):  o_word = ICAP_SYNC0;
        IDX_W'(1):  o_word = ICAP_SYNC1;
        IDX_W'(2):  o_word = ICAP_GEN1;
        IDX_W'(3):  o_word = i_addr[15:0];
        IDX_W'(4):  o_word = ICAP_GEN2;
        IDX_W'(5):  o_word = {i_opcode, i_addr[23:16]};
        IDX_W'(6):  o_word = ICAP_GEN3;
        IDX_W'(7):  o_word = i_fallback[15:0];
        IDX_W'(8):  o_word = ICAP_GEN4;
        IDX_W'(9):  o_word = {i_opcode, i_fallback[23:16]};
        IDX_W'(10): o_word = ICAP_CMD;
        IDX_W'(11): o_word = ICAP_IPROG;
        default:    o_word = ICAP_NOOP;
      endcase
    end
  end

endmodule

// File: rtl/icap_multiboot.sv
// Keyed ICAP multiboot sequencer: latches a boot address and streams the IPROG sequence,
// stalling on ICAP BUSY. First CE-low word appears 2 clocks after the accepted request.
module icap_multiboot
  import icap_pkg::*;
#(
  parameter int          DUMMY_WORDS   = 4,
  parameter int          NOOP_WORDS    = 4,
  parameter logic [7:0]  SPI_OPCODE    = 8'h0B,
  parameter logic [23:0] FALLBACK_ADDR = 24'h000000,
  parameter logic [15:0] REBOOT_KEY    = 16'hB007
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic [15:0] i_req_key,
  input  logic [23:0] i_boot_addr,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_key_err,
  output logic        o_icap_ce_n,
  output logic        o_icap_write_n,
  output logic [15:0] o_icap_din,
  input  logic        i_icap_busy
);

  localparam int TOTAL = DUMMY_WORDS + 12 + NOOP_WORDS;
  localparam int IDX_W = $clog2(TOTAL + 1);

  icap_state_t      r_state;
  logic [IDX_W-1:0] r_index;
  logic [23:0]      r_addr;
  logic             r_busy;
  logic             r_done;
  logic             r_key_err;
  logic             r_ce_n;
  logic             r_write_n;
  logic [15:0]      r_din;

  logic             w_adv;
  logic             w_last;
  logic [IDX_W-1:0] w_rom_idx;
  logic [15:0]      w_rom_word;

  // The ROM is addressed with the index that will be current after this edge,
  // so the word lands in the output register together with the index update.
  assign w_adv     = (r_state == ST_SEND) && !i_icap_busy;
  assign w_last    = (r_index == IDX_W'(TOTAL - 1));
  assign w_rom_idx = w_adv ? (r_index + IDX_W'(1)) : r_index;

  icap_iprog_rom #(
    .DUMMY_WORDS (DUMMY_WORDS),
    .IDX_W       (IDX_W)
  ) u_rom (
    .i_idx      (w_rom_idx),
    .i_addr     (r_addr),
    .i_opcode   (SPI_OPCODE),
    .i_fallback (FALLBACK_ADDR),
    .o_word     (w_rom_word)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_index   <= '0;
      r_addr    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_key_err <= 1'b0;
      r_ce_n    <= 1'b1;
      r_write_n <= 1'b1;
      r_din     <= ICAP_DUMMY;
    end else begin
      r_key_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_req) begin
            if (i_req_key == REBOOT_KEY) begin
              r_addr    <= i_boot_addr;
              r_index   <= '0;
              r_busy    <= 1'b1;
              r_write_n <= 1'b0;
              r_ce_n    <= 1'b1;
              r_state   <= ST_SETUP;
            end else begin
              r_key_err <= 1'b1;
            end
          end
        end
        ST_SETUP: begin
          r_ce_n  <= 1'b0;
          r_din   <= w_rom_word;
          r_state <= ST_SEND;
        end
        ST_SEND: begin
          if (!i_icap_busy) begin
            if (w_last) begin
              r_ce_n  <= 1'b1;
              r_state <= ST_HOLD;
            end else begin
              r_index <= r_index + IDX_W'(1);
              r_din   <= w_rom_word;
            end
          end
        end
        ST_HOLD: begin
          r_write_n <= 1'b1;
          r_busy    <= 1'b0;
          r_done    <= 1'b1;
          r_state   <= ST_DONE;
        end
        ST_DONE: begin
          r_state <= ST_DONE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_key_err      = r_key_err;
  assign o_icap_ce_n    = r_ce_n;
  assign o_icap_write_n = r_write_n;
  assign o_icap_din     = r_din;

endmodule

// File: tb/tb_icap_multiboot.sv
// Directed bench for icap_multiboot: default and re-parameterised instances share clock and reset.
module tb_icap_multiboot;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_req, b_req;
  logic [15:0] a_key, b_key;
  logic [23:0] a_addr, b_addr;
  logic        a_ibusy, b_ibusy;
  logic        a_busy, a_done, a_kerr, a_ce_n, a_wn;
  logic        b_busy, b_done, b_kerr, b_ce_n, b_wn;
  logic [15:0] a_din, b_din;

  int n_assert = 0;
  int n_fail   = 0;

  logic [15:0] cap[$];
  logic [15:0] expq[$];
  logic [15:0] lit1 [20] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hAA99, 16'h5566,
                             16'h3261, 16'h2000, 16'h3281, 16'h0B1A, 16'h32A1, 16'h0000,
                             16'h32C1, 16'h0B00, 16'h30A1, 16'h000E, 16'h2000, 16'h2000,
                             16'h2000, 16'h2000};

  icap_multiboot dut_a (
    .i_clk(clk), .i_rst(rst), .i_req(a_req), .i_req_key(a_key), .i_boot_addr(a_addr),
    .o_busy(a_busy), .o_done(a_done), .o_key_err(a_kerr), .o_icap_ce_n(a_ce_n),
    .o_icap_write_n(a_wn), .o_icap_din(a_din), .i_icap_busy(a_ibusy)
  );

  icap_multiboot #(
    .DUMMY_WORDS(2), .NOOP_WORDS(1), .SPI_OPCODE(8'h6B), .FALLBACK_ADDR(24'h040000)
  ) dut_b (
    .i_clk(clk), .i_rst(rst), .i_req(b_req), .i_req_key(b_key), .i_boot_addr(b_addr),
    .o_busy(b_busy), .o_done(b_done), .o_key_err(b_kerr), .o_icap_ce_n(b_ce_n),
    .o_icap_write_n(b_wn), .o_icap_din(b_din), .i_icap_busy(b_ibusy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model(input int i, input int d, input logic [7:0] o,
                                        input logic [23:0] f, input logic [23:0] a);
    if (i < d) return 16'hFFFF;
    case (i - d)
      0:       return 16'hAA99;
      1:       return 16'h5566;
      2:       return 16'h3261;
      3:       return a[15:0];
      4:       return 16'h3281;
      5:       return {o, a[23:16]};
      6:       return 16'h32A1;
      7:       return f[15:0];
      8:       return 16'h32C1;
      9:       return {o, f[23:16]};
      10:      return 16'h30A1;
      11:      return 16'h000E;
      default: return 16'h2000;
    endcase
  endfunction

  task automatic build(input int d, input int n, input logic [7:0] o, input logic [23:0] f,
                       input logic [23:0] a, input int stall_at, input int stall_len);
    expq.delete();
    for (int i = 0; i < d + 12 + n; i++) begin
      expq.push_back(model(i, d, o, f, a));
      if (i == stall_at) repeat (stall_len) expq.push_back(model(i, d, o, f, a));
    end
  endtask

  task automatic build_lit1();
    expq.delete();
    for (int i = 0; i < 20; i++) expq.push_back(lit1[i]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic request(input int s, input logic [15:0] key, input logic [23:0] addr);
    @(negedge clk);
    if (s == 0) begin a_req = 1'b1; a_key = key; a_addr = addr; end
    else        begin b_req = 1'b1; b_key = key; b_addr = addr; end
    @(negedge clk);
    a_req = 1'b0;
    b_req = 1'b0;
  endtask

  // Called at the negedge of the SETUP cycle; records every CE-low word until done.
  task automatic capture(input int s, input int stall_at, input int stall_len,
                         input int rst_at, input int req_at);
    int celow = 0;
    int rem = 0;
    bit in_win = 0, stalled = 0, kerr_seen = 0, done_seen = 0;
    logic pre_wn = 1'b1, post_wn = 1'b1, prev_wn;
    logic ce, wn, dn, ke;
    logic [15:0] d;
    cap.delete();
    prev_wn = (s == 0) ? a_wn : b_wn;
    for (int c = 0; c < 100 && !done_seen; c++) begin
      @(negedge clk);
      a_req = 1'b0;
      ce = (s == 0) ? a_ce_n : b_ce_n;
      wn = (s == 0) ? a_wn   : b_wn;
      dn = (s == 0) ? a_done : b_done;
      ke = (s == 0) ? a_kerr : b_kerr;
      d  = (s == 0) ? a_din  : b_din;
      if (ke) kerr_seen = 1;
      if (!ce) begin
        if (!in_win) pre_wn = prev_wn;
        in_win = 1;
        if (celow == rst_at) begin
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          chk("rst_ce_n", 32'(a_ce_n), 32'd1);
          chk("rst_write_n", 32'(a_wn), 32'd1);
          chk("rst_busy", 32'(a_busy), 32'd0);
          chk("rst_din", 32'(a_din), 32'hFFFF);
          return;
        end
        if (celow == req_at) begin a_req = 1'b1; a_key = 16'hB007; a_addr = 24'hFFFFFF; end
        cap.push_back(d);
        if (celow == stall_at && !stalled) begin stalled = 1; rem = stall_len; end
        celow++;
      end else if (in_win) begin
        post_wn = wn;
        in_win = 0;
      end
      if (dn) done_seen = 1;
      a_ibusy = (rem > 0);
      if (rem > 0) rem--;
      prev_wn = wn;
    end
    chk("done_reached", 32'(done_seen), 32'd1);
    chk("wn_before_ce", 32'(pre_wn), 32'd0);
    chk("wn_after_ce", 32'(post_wn), 32'd0);
    chk("no_key_err", 32'(kerr_seen), 32'd0);
    chk("word_count", 32'(cap.size()), 32'(expq.size()));
    for (int i = 0; i < cap.size() && i < expq.size(); i++)
      chk($sformatf("word%0d", i), 32'(cap[i]), 32'(expq[i]));
  endtask

  initial begin
    bit bad;
    rst = 1'b1;
    a_req = 1'b0; b_req = 1'b0; a_key = '0; b_key = '0;
    a_addr = '0; b_addr = '0; a_ibusy = 1'b0; b_ibusy = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy0", 32'(a_busy), 32'd0);
    chk("rst_done0", 32'(a_done), 32'd0);
    chk("rst_kerr0", 32'(a_kerr), 32'd0);
    chk("rst_ce_n0", 32'(a_ce_n), 32'd1);
    chk("rst_wn0", 32'(a_wn), 32'd1);
    chk("rst_din0", 32'(a_din), 32'hFFFF);
    chk("rst_b_din0", 32'(b_din), 32'hFFFF);
    rst = 1'b0;

    // Wrong key: one-cycle key_err, nothing else moves.
    request(0, 16'h1234, 24'h1A2000);
    chk("kerr_pulse", 32'(a_kerr), 32'd1);
    chk("kerr_busy", 32'(a_busy), 32'd0);
    chk("kerr_ce_n", 32'(a_ce_n), 32'd1);
    chk("kerr_wn", 32'(a_wn), 32'd1);
    @(negedge clk);
    chk("kerr_clear", 32'(a_kerr), 32'd0);
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (a_ce_n !== 1'b1 || a_wn !== 1'b1 || a_busy !== 1'b0) bad = 1;
    end
    chk("kerr_quiet", 32'(bad), 32'd0);

    // Default sequence.
    build_lit1();
    request(0, 16'hB007, 24'h1A2000);
    chk("setup_busy", 32'(a_busy), 32'd1);
    chk("setup_ce_n", 32'(a_ce_n), 32'd1);
    capture(0, -1, 0, -1, -1);
    chk("t1_done", 32'(a_done), 32'd1);
    chk("t1_busy", 32'(a_busy), 32'd0);
    chk("t1_wn", 32'(a_wn), 32'd1);

    // ICAP BUSY stall on GEN1 header.
    do_reset();
    chk("t3_done_cleared", 32'(a_done), 32'd0);
    build(4, 4, 8'h0B, 24'h000000, 24'h1A2000, 6, 3);
    request(0, 16'hB007, 24'h1A2000);
    capture(0, 6, 3, -1, -1);

    // Reset mid-stream, then a full replay.
    do_reset();
    request(0, 16'hB007, 24'h1A2000);
    capture(0, -1, 0, 10, -1);
    build_lit1();
    request(0, 16'hB007, 24'h1A2000);
    capture(0, -1, 0, -1, -1);

    // Requests during SEND and after DONE are ignored.
    do_reset();
    build(4, 4, 8'h0B, 24'h000000, 24'h123456, -1, 0);
    request(0, 16'hB007, 24'h123456);
    capture(0, -1, 0, -1, 12);
    request(0, 16'hB007, 24'h000000);
    bad = 0;
    repeat (4) begin
      if (a_kerr !== 1'b0 || a_busy !== 1'b0 || a_ce_n !== 1'b1 || a_done !== 1'b1) bad = 1;
      @(negedge clk);
    end
    chk("t5_after_done_quiet", 32'(bad), 32'd0);

    // Re-parameterised instance.
    build(2, 1, 8'h6B, 24'h040000, 24'h551234, -1, 0);
    request(1, 16'hB007, 24'h551234);
    capture(1, -1, 0, -1, -1);
    chk("t6_gen2_word", 32'(cap[7]), 32'h6B55);
    chk("t6_gen4_word", 32'(cap[11]), 32'h6B04);
    chk("t6_b_busy", 32'(b_busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
